uart_transmitter: RTL and testbench

Serial UART transmitter, the transmit-side counterpart of the game's UART receiver. Accepts bytes from game logic (score reports, status bytes) into a small FIFO and shifts each out as an 8N1 frame (optionally 8E1) on a single line. Sits beside the receiver in `pongTop`, sharing `clk_in` and `Rst`, and drives the board's UART TX pin.

---
 rtl/uart_transmitter.sv | 145 ++++++++++++++
 tb/tb_uart_transmitter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: byte FIFO feeding an 8N1 UART serializer.
// Optional even parity (8E1) is compiled in when UART_TX_PARITY_EN is defined.
// Bytes queue in a small FIFO; consecutive frames are sent with no idle gap.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] data_byte_in,
  input  logic       data_load,
  output logic       fifo_full,
  output logic       serial_data_out,
  output logic       tx_active,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FIFO_MAX = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t state, state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nxt;
  logic          fifo_empty, wr_en, pop;

  logic [CW-1:0] baud_cnt;
  logic          baud_last;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;

  assign fifo_empty = (count == '0);
  // A write while full is dropped even when a pop happens in the same cycle.
  assign wr_en      = data_load & ~fifo_full;
  assign baud_last  = (baud_cnt == BAUD_MAX);

  // FIFO storage; written only outside reset so loads during reset are ignored
  always_ff @(posedge clk_in) begin
    if (!reset && wr_en) mem[wr_ptr] <= data_byte_in;
  end

  // FIFO occupancy after this cycle's write/pop
  always_comb begin
    count_nxt = count;
    if (wr_en && !pop)      count_nxt = count + (PW+1)'(1);
    else if (!wr_en && pop) count_nxt = count - (PW+1)'(1);
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // FSM next state; pop the FIFO head whenever a new frame is launched
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: if (!fifo_empty) begin
        state_d = S_START;
        pop     = 1'b1;
      end
      S_START: if (baud_last) state_d = S_DATA;
      S_DATA: if (baud_last && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
        state_d = S_PARITY;
`else
        state_d = S_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (baud_last) state_d = S_STOP;
`endif
      S_STOP: if (baud_last) begin
        // Chain straight into the next start bit when more data is waiting.
        if (!fifo_empty) begin
          state_d = S_START;
          pop     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: line level and activity decoded from the current state
  always_comb begin
    serial_data_out = 1'b1;
    tx_active       = 1'b1;
    case (state)
      S_IDLE:   tx_active       = 1'b0;
      S_START:  serial_data_out = 1'b0;
      S_DATA:   serial_data_out = shift_reg[bit_idx];
`ifdef UART_TX_PARITY_EN
      S_PARITY: serial_data_out = ^shift_reg;
`endif
      S_STOP:   serial_data_out = 1'b1;
      default:  tx_active       = 1'b0;
    endcase
  end

  // Datapath: FIFO pointers/count, baud and bit counters, shifter, done pulse
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_done   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        shift_reg <= mem[rd_ptr];
      end
      count     <= count_nxt;
      fifo_full <= (count_nxt == FIFO_MAX);
      // Baud counter restarts at every bit boundary and idles at zero.
      if (state == S_IDLE || baud_last) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + CW'(1);
      // Index wraps 7 -> 0 at the end of the data phase, ready for the next frame.
      if (state == S_DATA && baud_last) bit_idx <= bit_idx + 3'd1;
      tx_done <= (state == S_STOP) && baud_last;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench; a line monitor decodes frames and
// compares them against bytes queued when stimulus is driven.
module tb_uart_transmitter;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FCYC = NBITS * CPB;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_byte_in = 8'h00;
  logic       data_load = 1'b0;
  logic       fifo_full, serial_data_out, tx_active, tx_done;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .data_byte_in    (data_byte_in),
    .data_load       (data_load),
    .fifo_full       (fifo_full),
    .serial_data_out (serial_data_out),
    .tx_active       (tx_active),
    .tx_done         (tx_done)
  );

  always #5 clk_in = ~clk_in;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] sb [$];
  int         starts [$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         act_cnt = 0;
  int         nframes = 0;
  logic       in_frame = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // cycle counter and per-cycle activity statistics
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) begin
    if (tx_done)   done_cnt <= done_cnt + 1;
    if (tx_active) act_cnt  <= act_cnt + 1;
  end

  // line monitor: samples every cycle of a frame, checks hold time, stop bit,
  // data/parity against the scoreboard and the tx_done pulse right after it
  initial begin : mon
    logic [NBITS-1:0] bits;
    logic             ok, pend, abort;
    logic [7:0]       exp_b;
    pend = 1'b0;
    forever begin
      @(negedge clk_in);
      if (pend) begin
        chk("done_pulse", {31'd0, tx_done}, 32'd1);
        pend = 1'b0;
      end
      if (!reset && serial_data_out == 1'b0) begin
        in_frame = 1'b1;
        starts.push_back(cyc);
        ok = 1'b1; abort = 1'b0; bits = '0;
        for (int k = 0; k < FCYC; k++) begin
          if (k > 0) @(negedge clk_in);
          if (reset) begin abort = 1'b1; break; end
          if (k % CPB == 0) bits[k / CPB] = serial_data_out;
          else if (serial_data_out !== bits[k / CPB]) ok = 1'b0;
          if (!tx_active) ok = 1'b0;
          if (k > 0 && tx_done) ok = 1'b0;
        end
        if (!abort) begin
          nframes++;
          chk("bit_hold", {31'd0, ok}, 32'd1);
          chk("stop_bit", {31'd0, bits[NBITS-1]}, 32'd1);
          if (sb.size() == 0) chk("unexpected_frame", sb.size(), 32'd1);
          else begin
            exp_b = sb.pop_front();
            chk("data", {24'd0, bits[8:1]}, {24'd0, exp_b});
`ifdef UART_TX_PARITY_EN
            chk("parity", {31'd0, bits[9]}, {31'd0, ^exp_b});
`endif
          end
          pend = 1'b1;
        end
        in_frame = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    data_load    = 1'b1;
    data_byte_in = b;
    tick();
    data_load    = 1'b0;
    data_byte_in = ~b;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || tx_active || in_frame) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_timeout", {31'd0, n < 3000}, 32'd1);
    repeat (3) tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int lc, d0, a0, f0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_line", {31'd0, serial_data_out}, 32'd1);
    chk("rst_active", {31'd0, tx_active}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    reset = 1'b0;
    tick();

    // single byte from idle
    starts.delete(); d0 = done_cnt;
    sb.push_back(8'hA5);
    load(8'hA5);
    lc = cyc;
    drain();
    chk("t1_frames", starts.size(), 32'd1);
    chk("t1_start_lat", (starts.size() > 0) ? starts[0] - lc : -1, 32'd1);
    chk("t1_done_cnt", done_cnt - d0, 32'd1);

    // back-to-back frames
    starts.delete(); d0 = done_cnt; a0 = act_cnt;
    for (int i = 1; i <= 3; i++) sb.push_back(8'(i));
    for (int i = 1; i <= 3; i++) load(8'(i));
    drain();
    chk("t2_frames", starts.size(), 32'd3);
    if (starts.size() == 3) begin
      chk("t2_gap1", starts[1] - starts[0], FCYC);
      chk("t2_gap2", starts[2] - starts[1], FCYC);
    end
    chk("t2_active", act_cnt - a0, 3 * FCYC);
    chk("t2_done_cnt", done_cnt - d0, 32'd3);

    // overflow: sixth byte dropped
    d0 = done_cnt; f0 = nframes;
    for (int i = 0; i < 5; i++) sb.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 6; i++) begin
      load(8'h10 + 8'(i));
      if (i == 3) chk("t3_full_w4", {31'd0, fifo_full}, 32'd0);
      if (i >= 4) chk("t3_full_w5", {31'd0, fifo_full}, 32'd1);
    end
    drain();
    chk("t3_frames", nframes - f0, 32'd5);
    chk("t3_done_cnt", done_cnt - d0, 32'd5);
    chk("t3_full_end", {31'd0, fifo_full}, 32'd0);

`ifdef UART_TX_PARITY_EN
    // parity: 0x07 -> 1, 0x03 -> 0 (checked by the monitor)
    starts.delete();
    sb.push_back(8'h07); sb.push_back(8'h03);
    load(8'h07); load(8'h03);
    drain();
    chk("t4_frames", starts.size(), 32'd2);
    if (starts.size() == 2) chk("t4_len", starts[1] - starts[0], 32'd44);
`endif

    // reset during data bit 3 of 0xFF with two bytes queued
    sb.push_back(8'hFF);
    load(8'hFF); load(8'hAA); load(8'h55);
    chk("t5_active", {31'd0, tx_active}, 32'd1);
    repeat (16) tick();
    reset = 1'b1; data_load = 1'b1; data_byte_in = 8'h77;
    tick();
    chk("t5_line", {31'd0, serial_data_out}, 32'd1);
    chk("t5_active_rst", {31'd0, tx_active}, 32'd0);
    chk("t5_full_rst", {31'd0, fifo_full}, 32'd0);
    reset = 1'b0; data_load = 1'b0;
    sb.delete();
    d0 = done_cnt; f0 = nframes;
    repeat (200) tick();
    chk("t5_no_frames", nframes - f0, 32'd0);
    chk("t5_no_done", done_cnt - d0, 32'd0);
    sb.push_back(8'h3C);
    load(8'h3C);
    drain();
    chk("t5_resume", nframes - f0, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
